// File: rtl/irq_request_latch_if.sv
// Bundle of request, clear and status signals between the request latch
// and whatever drives it (the encoder/consumer side).
interface irq_request_latch_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic       clr_valid;
  logic [2:0] clr_code;
  logic       clr_all;
  logic       ovf_clr;
  logic [7:0] pend;
  logic       irq;
  logic [7:0] overflow;

  // Driver side: produces requests and clears, observes status
  modport master (
    output req, mask, clr_valid, clr_code, clr_all, ovf_clr,
    input  pend, irq, overflow
  );

  // Latch side: consumes requests and clears, produces status
  modport slave (
    input  req, mask, clr_valid, clr_code, clr_all, ovf_clr,
    output pend, irq, overflow
  );
endinterface

// File: rtl/irq_request_latch.sv
// Front end of the 8-input priority encoder: synchronises eight async
// request lines, latches rising edges as pending bits until the consumer
// clears them by encoder code, and flags requests lost while pending.
module irq_request_latch #(
  parameter int SYNC_STAGES = 2,  // synchroniser depth, 2..4
  parameter int EDGE_MODE   = 1   // 1 = edge capture, 0 = level follow
) (
  input logic               clk,
  input logic               rst_n,
  irq_request_latch_if.slave bus
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] hist_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] overflow_q, overflow_d;
  logic [7:0] sync_s;
  logic [7:0] edge_s;
  logic [7:0] clr_s;
  logic [7:0] ovf_evt_s;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign edge_s = sync_s & ~hist_q;

  // Per-channel clear decode from the encoder code
  for (genvar gi = 0; gi < 8; gi++) begin : g_clr
    assign clr_s[gi] = bus.clr_all | (bus.clr_valid && (bus.clr_code == 3'(gi)));
  end

  // Next pending/overflow state; a new edge beats a same-cycle clear
  always_comb begin
    pending_d = pending_q;
    ovf_evt_s = '0;
    if (EDGE_MODE != 0) begin
      pending_d = edge_s | (pending_q & ~clr_s);
      ovf_evt_s = edge_s & pending_q & ~clr_s;
    end else begin
      pending_d = sync_s;
    end
    overflow_d = bus.ovf_clr ? ovf_evt_s : (overflow_q | ovf_evt_s);
    pend_d     = pending_d & bus.mask;
  end

  // Synchroniser chain and edge history (history resets low so a request
  // held high through reset is still seen as an edge)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req};
      end else begin
        sync_q <= bus.req;
      end
      hist_q <= sync_s;
    end
  end

  // Pending, visible pend and sticky overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      pend_q     <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.pend     = pend_q;
  assign bus.irq      = |pend_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_irq_request_latch.sv
module tb_irq_request_latch;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  irq_request_latch_if e_if ();  // edge-mode DUT
  irq_request_latch_if l_if ();  // level-mode DUT

  irq_request_latch #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut_edge (
    .clk(clk), .rst_n(rst_n), .bus(e_if.slave));
  irq_request_latch #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut_level (
    .clk(clk), .rst_n(rst_n), .bus(l_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: got %h want %h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    e_if.req = 8'h00; e_if.mask = 8'hFF; e_if.clr_valid = 1'b0; e_if.clr_code = 3'd0;
    e_if.clr_all = 1'b0; e_if.ovf_clr = 1'b0;
    l_if.req = 8'h00; l_if.mask = 8'h00; l_if.clr_valid = 1'b0; l_if.clr_code = 3'd0;
    l_if.clr_all = 1'b0; l_if.ovf_clr = 1'b0;
    #1;
    check("reset_pend", e_if.pend, 8'h00);
    check("reset_irq", {7'd0, e_if.irq}, 8'h00);
    check("reset_ovf", e_if.overflow, 8'h00);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Single edge on channel 5: visible after SYNC_STAGES+1 edges
    e_if.req = 8'h20;
    step(2);
    check("edge_not_yet", e_if.pend, 8'h00);
    step(1);
    check("edge_pend", e_if.pend, 8'h20);
    check("edge_irq", {7'd0, e_if.irq}, 8'h01);
    check("edge_ovf", e_if.overflow, 8'h00);

    // Service loop: clear 7 then 5
    e_if.req = 8'hA0;
    step(3);
    check("svc_pend_a0", e_if.pend, 8'hA0);
    e_if.clr_valid = 1'b1; e_if.clr_code = 3'd7;
    step(1);
    check("svc_clr7", e_if.pend, 8'h20);
    e_if.clr_code = 3'd5;
    step(1);
    check("svc_clr5", e_if.pend, 8'h00);
    check("svc_irq0", {7'd0, e_if.irq}, 8'h00);
    e_if.clr_valid = 1'b0;
    e_if.req = 8'h00;
    step(4);

    // Set and clear in the same cycle on channel 3
    e_if.req = 8'h08;
    step(3);
    check("ch3_pend", e_if.pend, 8'h08);
    e_if.req = 8'h00;
    step(3);
    e_if.req = 8'h08;
    step(2);                       // edge is now visible combinationally
    e_if.clr_valid = 1'b1; e_if.clr_code = 3'd3;
    step(1);
    e_if.clr_valid = 1'b0;
    check("setclr_pend", e_if.pend, 8'h08);
    check("setclr_ovf", e_if.overflow, 8'h00);

    // Same edge without a clear: overflow, sticky until ovf_clr
    e_if.req = 8'h00;
    step(3);
    e_if.req = 8'h08;
    step(3);
    check("ovf_set", e_if.overflow, 8'h08);
    step(2);
    check("ovf_sticky", e_if.overflow, 8'h08);
    e_if.ovf_clr = 1'b1;
    step(1);
    e_if.ovf_clr = 1'b0;
    check("ovf_cleared", e_if.overflow, 8'h00);

    // ovf_clr coinciding with a new overflow event: the event wins
    e_if.req = 8'h00;
    step(3);
    e_if.req = 8'h08;
    step(2);
    e_if.ovf_clr = 1'b1;
    step(1);
    e_if.ovf_clr = 1'b0;
    check("ovf_evt_wins", e_if.overflow, 8'h08);
    e_if.ovf_clr = 1'b1;
    step(1);
    e_if.ovf_clr = 1'b0;
    check("ovf_clr2", e_if.overflow, 8'h00);

    // Clear of a non-pending channel is harmless; clr_all empties
    e_if.clr_valid = 1'b1; e_if.clr_code = 3'd2;
    step(1);
    e_if.clr_valid = 1'b0;
    check("clr_nonpend", e_if.pend, 8'h08);
    e_if.clr_all = 1'b1;
    step(1);
    e_if.clr_all = 1'b0;
    check("clr_all", e_if.pend, 8'h00);
    e_if.req = 8'h00;
    step(3);

    // Mask hold: requests stay pending while hidden
    e_if.mask = 8'h00;
    e_if.req  = 8'h41;
    step(4);
    check("mask_hidden", e_if.pend, 8'h00);
    check("mask_irq0", {7'd0, e_if.irq}, 8'h00);
    e_if.mask = 8'hFF;
    step(1);
    check("mask_reveal", e_if.pend, 8'h41);
    check("mask_irq1", {7'd0, e_if.irq}, 8'h01);

    // Build overflow on channel 0, then async reset mid-cycle
    e_if.req = 8'h40;
    step(3);
    e_if.req = 8'h41;
    step(3);
    check("pre_rst_ovf", e_if.overflow, 8'h01);
    check("pre_rst_pend", e_if.pend, 8'h41);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pend", e_if.pend, 8'h00);
    check("async_rst_irq", {7'd0, e_if.irq}, 8'h00);
    check("async_rst_ovf", e_if.overflow, 8'h00);
    rst_n = 1'b1;
    step(2);
    check("post_rst_wait", e_if.pend, 8'h00);
    step(1);
    check("post_rst_pend", e_if.pend, 8'h41);
    check("post_rst_ovf", e_if.overflow, 8'h00);

    // Level mode: pend follows synchronised level, clears ignored
    l_if.mask = 8'h04;
    l_if.req  = 8'h0C;
    step(2);
    check("lvl_not_yet", l_if.pend, 8'h00);
    step(1);
    check("lvl_pend", l_if.pend, 8'h04);
    check("lvl_irq", {7'd0, l_if.irq}, 8'h01);
    l_if.clr_valid = 1'b1; l_if.clr_code = 3'd2;
    step(1);
    l_if.clr_valid = 1'b0;
    check("lvl_clr_ignored", l_if.pend, 8'h04);
    l_if.req = 8'h00;
    step(2);
    check("lvl_drop_wait", l_if.pend, 8'h04);
    step(1);
    check("lvl_drop", l_if.pend, 8'h00);
    check("lvl_ovf", l_if.overflow, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
